regfile_write_arbiter: RTL and testbench

Two-requester write-port arbiter and scheduler for the 32×32-bit general register file. Two write-back sources (A: memory/load path, B: ALU path) each hand a write to the arbiter over a valid/ready handshake. The arbiter buffers one write per source, issues at most one registered write per clock to the register file's single write port in age order, and publishes a per-register pending mask that the decode stage uses for hazard stalls.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_write_arbiter_if.sv | 32 +++
 rtl/wb_slot.sv | 43 ++++
 rtl/regfile_write_arbiter.sv | 111 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write arbiter.
// Contents: register file geometry, the write-request record carried by each
// source, and the hardwired-zero register index.
package regfile_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  // Register 0 is hardwired to zero; writes to it are dropped on entry.
  localparam logic [ADDR_W-1:0] ZERO_REG = {ADDR_W{1'b0}};

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bus bundle between the two write-back sources, the arbiter and the
// register file / decode stage.
// Signals: a_* / b_* valid-ready write requests (addr, data), rf_* registered
// register-file write port, pend_mask per-register pending-write mask.
// Modports: slave = the arbiter, master = the sources and consumers around it.
interface regfile_write_arbiter_if;
  import regfile_pkg::*;

  logic                a_valid;
  logic                a_ready;
  logic [ADDR_W-1:0]   a_addr;
  logic [DATA_W-1:0]   a_data;
  logic                b_valid;
  logic                b_ready;
  logic [ADDR_W-1:0]   b_addr;
  logic [DATA_W-1:0]   b_data;
  logic                rf_we;
  logic [ADDR_W-1:0]   rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;
  logic [NUM_REGS-1:0] pend_mask;

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, rf_we, rf_waddr, rf_wdata, pend_mask
  );

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, rf_we, rf_waddr, rf_wdata, pend_mask
  );

endinterface

// File: rtl/wb_slot.sv
// One-entry holding register for a single write-back source.
// Ports: clk, rst_n (async active-low); accept = handshake completes this edge;
// req_in = incoming write; clear = slot granted this edge; full / req_out =
// current contents; fill = this edge loads a real (non-zero-address) write.
module wb_slot
  import regfile_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    accept,
  input  wr_req_t req_in,
  input  logic    clear,
  output logic    full,
  output wr_req_t req_out,
  output logic    fill
);

  logic    full_r;
  wr_req_t req_r;

  // A handshake to register 0 completes but never occupies the slot.
  assign fill    = accept && (req_in.addr != ZERO_REG);
  assign full    = full_r;
  assign req_out = req_r;

  // Slot state: a fill takes priority over clear so a granted slot can refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_r <= 1'b0;
      req_r  <= '0;
    end else if (fill) begin
      full_r <= 1'b1;
      req_r  <= req_in;
    end else if (clear) begin
      full_r <= 1'b0;
      req_r  <= req_r;
    end else begin
      full_r <= full_r;
      req_r  <= req_r;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-source write arbiter for the 32x32 register file.
// Ports: clk, rst_n (async active-low), bus (slave modport) carrying the two
// valid/ready write sources, the registered register-file write port and the
// per-register pending mask used by decode for hazard stalls.
// Issues at most one write per clock, oldest slot first.
module regfile_write_arbiter
  import regfile_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  regfile_write_arbiter_if.slave   bus
);

  logic          a_full_s, b_full_s;
  logic          a_fill_s, b_fill_s;
  wr_req_t       a_req_s, b_req_s;
  logic          grant_a_s, grant_b_s;
  logic          a_ready_s, b_ready_s;
  logic          a_older_r;
  logic          rf_we_r;
  logic [ADDR_W-1:0]   rf_waddr_r;
  logic [DATA_W-1:0]   rf_wdata_r;
  logic [NUM_REGS-1:0] pend_s;

  wb_slot u_slot_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .accept  (bus.a_valid && a_ready_s),
    .req_in  ({bus.a_addr, bus.a_data}),
    .clear   (grant_a_s),
    .full    (a_full_s),
    .req_out (a_req_s),
    .fill    (a_fill_s)
  );

  wb_slot u_slot_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .accept  (bus.b_valid && b_ready_s),
    .req_in  ({bus.b_addr, bus.b_data}),
    .clear   (grant_b_s),
    .full    (b_full_s),
    .req_out (b_req_s),
    .fill    (b_fill_s)
  );

  // Grant and ready: A wins when alone or older; B takes any remaining full slot.
  always_comb begin
    grant_a_s = a_full_s && (!b_full_s || a_older_r);
    grant_b_s = b_full_s && !grant_a_s;
    a_ready_s = rst_n && (!a_full_s || grant_a_s);
    b_ready_s = rst_n && (!b_full_s || grant_b_s);
  end

  assign bus.a_ready = a_ready_s;
  assign bus.b_ready = b_ready_s;

  // Age flag: only meaningful once both slots hold writes; a slot that stays
  // full across the edge is older than one that was just (re)filled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_older_r <= 1'b1;
    end else if (a_fill_s && b_fill_s) begin
      a_older_r <= 1'b1;
    end else if (b_fill_s && a_full_s && !grant_a_s) begin
      a_older_r <= 1'b1;
    end else if (a_fill_s && b_full_s && !grant_b_s) begin
      a_older_r <= 1'b0;
    end else begin
      a_older_r <= a_older_r;
    end
  end

  // Register-file write port; address/data hold when nothing is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= {ADDR_W{1'b0}};
      rf_wdata_r <= {DATA_W{1'b0}};
    end else if (grant_a_s) begin
      rf_we_r    <= 1'b1;
      rf_waddr_r <= a_req_s.addr;
      rf_wdata_r <= a_req_s.data;
    end else if (grant_b_s) begin
      rf_we_r    <= 1'b1;
      rf_waddr_r <= b_req_s.addr;
      rf_wdata_r <= b_req_s.data;
    end else begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= rf_waddr_r;
      rf_wdata_r <= rf_wdata_r;
    end
  end

  assign bus.rf_we    = rf_we_r;
  assign bus.rf_waddr = rf_waddr_r;
  assign bus.rf_wdata = rf_wdata_r;

  // Pending decode from buffered and in-flight writes; register 0 never pends.
  always_comb begin
    pend_s = {NUM_REGS{1'b0}};
    for (int k = 1; k < NUM_REGS; k++) begin
      pend_s[k] = (a_full_s && (a_req_s.addr == ADDR_W'(k))) ||
                  (b_full_s && (b_req_s.addr == ADDR_W'(k))) ||
                  (rf_we_r  && (rf_waddr_r   == ADDR_W'(k)));
    end
  end

  assign bus.pend_mask = pend_s;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios with
// literal expectations plus a randomized phase, all cross-checked every cycle
// against an acceptance-ordered queue model of the arbiter.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  logic clk;
  logic rst_n;
  regfile_write_arbiter_if bus ();

  regfile_write_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Every accepted non-zero write joins one queue in acceptance order (A ahead
  // of B on a tie). The head is issued each clock. A source may hand over a new
  // write when it has nothing queued or its queued write is the one leaving.
  typedef struct {
    bit          src;   // 0 = A, 1 = B
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  function automatic bit m_ready(input bit src);
    bit queued;
    if (!rst_n) return 1'b0;
    queued = 1'b0;
    foreach (q[i]) if (q[i].src == src) queued = 1'b1;
    return !queued || (q.size() > 0 && q[0].src == src);
  endfunction

  function automatic logic [31:0] m_pend();
    logic [31:0] m;
    m = 32'd0;
    foreach (q[i]) m[q[i].addr] = 1'b1;
    if (m_we) m[m_waddr] = 1'b1;
    return m;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit   ra, rb;
    ent_t h;
    if (!rst_n) begin
      q.delete();
      m_we    = 1'b0;
      m_waddr = 5'd0;
      m_wdata = 32'd0;
    end else begin
      ra = m_ready(1'b0);
      rb = m_ready(1'b1);
      if (q.size() > 0) begin
        h       = q.pop_front();
        m_we    = 1'b1;
        m_waddr = h.addr;
        m_wdata = h.data;
      end else begin
        m_we = 1'b0;
      end
      if (bus.a_valid && ra && bus.a_addr != 5'd0)
        q.push_back('{src: 1'b0, addr: bus.a_addr, data: bus.a_data});
      if (bus.b_valid && rb && bus.b_addr != 5'd0)
        q.push_back('{src: 1'b1, addr: bus.b_addr, data: bus.b_data});
    end
  end

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    chk("m_a_ready", 64'(bus.a_ready),   64'(m_ready(1'b0)));
    chk("m_b_ready", 64'(bus.b_ready),   64'(m_ready(1'b1)));
    chk("m_rf_we",   64'(bus.rf_we),     64'(m_we));
    chk("m_waddr",   64'(bus.rf_waddr),  64'(m_waddr));
    chk("m_wdata",   64'(bus.rf_wdata),  64'(m_wdata));
    chk("m_pend",    64'(bus.pend_mask), 64'(m_pend()));
  end

  // Issue log of what the register file actually received.
  logic [36:0] issued[$];
  always @(negedge clk) if (bus.rf_we === 1'b1) issued.push_back({bus.rf_waddr, bus.rf_wdata});

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    bus.a_addr  = 5'd0; bus.b_addr  = 5'd0;
    bus.a_data  = 32'd0; bus.b_data = 32'd0;
  endtask

  int ia, ib;
  bit acc_a, acc_b;

  initial begin
    // Reset with both sources requesting.
    rst_n = 1'b0;
    idle();
    bus.a_valid = 1'b1; bus.a_addr = 5'd4;
    bus.b_valid = 1'b1; bus.b_addr = 5'd6;
    repeat (3) step();
    chk("rst_a_ready", 64'(bus.a_ready), 64'd0);
    chk("rst_b_ready", 64'(bus.b_ready), 64'd0);
    chk("rst_rf_we",   64'(bus.rf_we),   64'd0);
    chk("rst_pend",    64'(bus.pend_mask), 64'd0);
    idle();
    rst_n = 1'b1;
    #1;
    chk("rel_a_ready", 64'(bus.a_ready), 64'd1);
    chk("rel_b_ready", 64'(bus.b_ready), 64'd1);
    step();
    chk("rel_rf_we",   64'(bus.rf_we),   64'd0);
    chk("rel_pend",    64'(bus.pend_mask), 64'd0);

    // Single write A -> r5.
    bus.a_valid = 1'b1; bus.a_addr = 5'd5; bus.a_data = 32'hDEAD_BEEF;
    step(); idle();
    chk("single_pend_e1", 64'(bus.pend_mask), 64'h20);
    chk("single_we_e1",   64'(bus.rf_we), 64'd0);
    step();
    chk("single_we_e2",    64'(bus.rf_we),    64'd1);
    chk("single_waddr_e2", 64'(bus.rf_waddr), 64'd5);
    chk("single_wdata_e2", 64'(bus.rf_wdata), 64'hDEAD_BEEF);
    chk("single_pend_e2",  64'(bus.pend_mask), 64'h20);
    step();
    chk("single_we_e3",   64'(bus.rf_we), 64'd0);
    chk("single_pend_e3", 64'(bus.pend_mask), 64'd0);

    // Same-address collision on r3.
    bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.a_data = 32'd1;
    bus.b_valid = 1'b1; bus.b_addr = 5'd3; bus.b_data = 32'd2;
    step(); idle();
    chk("coll_pend_e1",  64'(bus.pend_mask), 64'h8);
    step();
    chk("coll_first",    64'(bus.rf_wdata), 64'd1);
    chk("coll_we_e2",    64'(bus.rf_we), 64'd1);
    chk("coll_pend_e2",  64'(bus.pend_mask), 64'h8);
    step();
    chk("coll_second",   64'(bus.rf_wdata), 64'd2);
    chk("coll_we_e3",    64'(bus.rf_we), 64'd1);
    chk("coll_pend_e3",  64'(bus.pend_mask), 64'h8);
    step();
    chk("coll_pend_e4",  64'(bus.pend_mask), 64'd0);

    // Zero register write from B.
    bus.b_valid = 1'b1; bus.b_addr = 5'd0; bus.b_data = 32'hFFFF_FFFF;
    chk("zero_b_ready", 64'(bus.b_ready), 64'd1);
    step(); idle();
    chk("zero_we_e1",   64'(bus.rf_we), 64'd0);
    chk("zero_pend_e1", 64'(bus.pend_mask), 64'd0);
    step();
    chk("zero_we_e2",   64'(bus.rf_we), 64'd0);

    // Saturation: both sources valid for 8 edges with distinct addresses.
    issued.delete();
    ia = 0; ib = 0;
    for (int c = 0; c < 8; c++) begin
      bus.a_valid = 1'b1; bus.a_addr = 5'(1 + ia);  bus.a_data = 32'hA000_0000 + 32'(ia);
      bus.b_valid = 1'b1; bus.b_addr = 5'(16 + ib); bus.b_data = 32'hB000_0000 + 32'(ib);
      acc_a = bus.a_ready;
      acc_b = bus.b_ready;
      step();
      if (acc_a) ia++;
      if (acc_b) ib++;
    end
    idle();
    repeat (4) step();
    chk("sat_a_accepted", 64'(ia), 64'd5);
    chk("sat_b_accepted", 64'(ib), 64'd4);
    chk("sat_issued",     64'(issued.size()), 64'd9);
    for (int i = 0; i < issued.size() && i < 9; i++) begin
      if (i % 2 == 0)
        chk("sat_order_a", 64'(issued[i]), 64'({5'(1 + i/2), 32'hA000_0000 + 32'(i/2)}));
      else
        chk("sat_order_b", 64'(issued[i]), 64'({5'(16 + i/2), 32'hB000_0000 + 32'(i/2)}));
    end

    // Mid-operation reset: both slots full and a write in flight.
    bus.a_valid = 1'b1; bus.a_addr = 5'd7; bus.a_data = 32'h7777;
    bus.b_valid = 1'b1; bus.b_addr = 5'd9; bus.b_data = 32'h9999;
    step();
    bus.a_data = 32'h7778;
    step(); idle();
    chk("mid_we_before",   64'(bus.rf_we), 64'd1);
    chk("mid_pend_before", 64'(bus.pend_mask), 64'h280);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_we_rst",   64'(bus.rf_we), 64'd0);
    chk("mid_pend_rst", 64'(bus.pend_mask), 64'd0);
    chk("mid_waddr_rst", 64'(bus.rf_waddr), 64'd0);
    chk("mid_wdata_rst", 64'(bus.rf_wdata), 64'd0);
    chk("mid_ready_rst", 64'({bus.a_ready, bus.b_ready}), 64'd0);
    #1 rst_n = 1'b1;
    issued.delete();
    repeat (4) step();
    chk("mid_no_issue", 64'(issued.size()), 64'd0);

    // Randomized traffic, checked by the model on every cycle.
    for (int c = 0; c < 400; c++) begin
      bus.a_valid = 1'($urandom_range(0, 1));
      bus.b_valid = 1'($urandom_range(0, 1));
      bus.a_addr  = 5'($urandom_range(0, 31));
      bus.b_addr  = ($urandom_range(0, 3) == 0) ? bus.a_addr : 5'($urandom_range(0, 31));
      bus.a_data  = $urandom;
      bus.b_data  = $urandom;
      if (c == 200) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      step();
    end
    idle();
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
